// File: rtl/sha3_sponge_sequencer.sv
// Sponge controller: absorbs 64-bit message words into a 1600-bit state, fires one Keccak-f[1600] pass per rate block, squeezes the digest.
// Latency: perm_sample one cycle after a block's last word is accepted; first digest word one cycle after the final perm_ogood.
// Backpressure: in_ready low outside ABSORB (words wait on the host side); each digest word is held until dig_ready.
// Optional: define SHA3_SEQ_STATS_EN to add the saturating perm_count output (permutations fired since reset).
module sha3_sponge_sequencer #(
    parameter int RATE_WORDS   = 17,
    parameter int DIGEST_WORDS = 4,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         perm_sample,
    output logic [319:0] perm_rowa,
    output logic [319:0] perm_rowb,
    output logic [319:0] perm_rowc,
    output logic [319:0] perm_rowd,
    output logic [319:0] perm_rowe,
    input  logic         perm_ogood,
    input  logic [319:0] perm_oa,
    input  logic [319:0] perm_ob,
    input  logic [319:0] perm_oc,
    input  logic [319:0] perm_od,
    input  logic [319:0] perm_oe,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [63:0]  dig_data,
    output logic         dig_last
`ifdef SHA3_SEQ_STATS_EN
    ,
    output logic [31:0]  perm_count
`endif
);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_ABSORB,
        S_FIRE,
        S_WAIT,
        S_SQUEEZE
    } state_t;

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t         state;
    state_t         state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [1599:0]  st;          // lane (x,y) lives at bits 64*(x+5y); row y is a contiguous 320-bit slice
    logic [4:0]     wcnt;        // next lane to absorb into
    logic [4:0]     dcnt;        // next digest lane to emit
    logic           last_flag;   // current block is the message's final block
    logic           drain_done;
    logic           wcnt_end;
    logic           dig_end;

    assign drain_done = (drain_cnt == DCW'(DRAIN_CYCLES - 1));
    assign wcnt_end   = (wcnt == 5'(RATE_WORDS - 1));
    assign dig_end    = (dcnt == 5'(DIGEST_WORDS - 1));

    assign perm_rowa = st[0    +: 320];
    assign perm_rowb = st[320  +: 320];
    assign perm_rowc = st[640  +: 320];
    assign perm_rowd = st[960  +: 320];
    assign perm_rowe = st[1280 +: 320];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_DRAIN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        perm_sample = 1'b0;
        dig_valid   = 1'b0;
        dig_last    = 1'b0;
        case (state)
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_ABSORB;
                end
            end
            S_ABSORB: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || wcnt_end)) begin
                    state_nxt = S_FIRE;
                end
            end
            S_FIRE: begin
                perm_sample = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (perm_ogood) begin
                    state_nxt = last_flag ? S_SQUEEZE : S_ABSORB;
                end
            end
            S_SQUEEZE: begin
                dig_valid = 1'b1;
                dig_last  = dig_end;
                if (dig_ready && dig_end) begin
                    state_nxt = S_ABSORB;
                end
            end
            default: begin
                state_nxt = S_DRAIN;
            end
        endcase
    end

    // Digest word mux; forced to zero whenever no digest word is on offer
    always_comb begin
        dig_data = '0;
        if (dig_valid) begin
            for (int i = 0; i < DIGEST_WORDS; i++) begin
                if (dcnt == 5'(i)) begin
                    dig_data = st[64*i +: 64];
                end
            end
        end
    end

    // Sponge state, lane/digest counters and drain timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            wcnt      <= '0;
            dcnt      <= '0;
            last_flag <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (state == S_DRAIN && !drain_done) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < RATE_WORDS; i++) begin
                    if (wcnt == 5'(i)) begin
                        st[64*i +: 64] <= st[64*i +: 64] ^ in_data;
                    end
                end
                wcnt <= wcnt + 1'b1;
                if (in_last) begin
                    last_flag <= 1'b1;
                end
            end
            if (state == S_FIRE) begin
                wcnt <= '0;
            end
            if (state == S_WAIT && perm_ogood) begin
                st <= {perm_oe, perm_od, perm_oc, perm_ob, perm_oa};
            end
            if (dig_valid && dig_ready) begin
                if (dig_end) begin
                    st        <= '0;
                    last_flag <= 1'b0;
                    dcnt      <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

`ifdef SHA3_SEQ_STATS_EN
    // Saturating count of permutations fired since reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perm_count <= '0;
        end else if (state == S_FIRE && perm_count != 32'hFFFF_FFFF) begin
            perm_count <= perm_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/sha3_sponge_sequencer.md
Name: sha3_sponge_sequencer

Overview:
Sponge-mode controller for the 24-round unrolled Keccak-f[1600] permutation pipeline. Accepts host-padded message words serially, XORs them into a 1600-bit state register and fires the permutation once per rate block. It captures the permuted state and, after the final block, streams the digest words out. Sits between a word-stream host interface and one permutation instance, with one message in flight at a time.

Parameters:
RATE_WORDS, 17, 64-bit lanes per rate block (17 = SHA3-256); legal range 1..24
DIGEST_WORDS, 4, 64-bit words emitted in squeeze; must be <= RATE_WORDS
DRAIN_CYCLES, 64, post-reset cycles during which stale permutation outputs are flushed; must exceed permutation latency

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  message word valid
in_ready  out  1  word accepted when in_valid&&in_ready
in_data  in  64  message word, lane order (word i -> lane x=i%5, y=i/5)
in_last  in  1  final word of final block of message
perm_sample  out  1  one-cycle strobe into permutation
perm_rowa..perm_rowe  out  5x64 each  state rows y=0..4; rowN[x] = lane(x,y)
perm_ogood  in  1  permutation output valid
perm_oa..perm_oe  in  5x64 each  permuted state rows, same mapping
dig_valid  out  1  digest word valid
dig_ready  in  1  digest word consumed when dig_valid&&dig_ready
dig_data  out  64  digest word k = lane k of final state
dig_last  out  1  high with word DIGEST_WORDS-1

Behaviour:
- Reset (async, active-high): state=DRAIN, drain counter=0, 1600-bit state register=0, word counter=0, last_flag=0; in_ready=0, perm_sample=0, dig_valid=0, dig_last=0, dig_data=0.
- perm_row* are driven continuously from the state register.
- DRAIN: counts DRAIN_CYCLES clocks and ignores perm_ogood, then goes to ABSORB.
- ABSORB: in_ready=1.
  - On each accept: lane[wcnt] ^= in_data; wcnt++.
  - If in_last: set last_flag.
  - If in_last, or wcnt==RATE_WORDS-1: go to FIRE next cycle. Lanes not written in the block stay unchanged (zero-XOR).
- FIRE: perm_sample=1 for exactly one cycle, carrying the fully updated state; in_ready=0; wcnt cleared. Go to WAIT. The strobe is the cycle after the last word is accepted.
- WAIT: on perm_ogood, all 25 lanes are loaded from perm_o*. Next state is SQUEEZE if last_flag, else ABSORB. perm_ogood is ignored in every state other than WAIT.
- SQUEEZE: dig_valid=1 from the cycle after capture; dig_data=lane[k], k=0..DIGEST_WORDS-1.
  - k advances only on handshake; dig_data is held stable while dig_ready=0.
  - dig_last=1 when k==DIGEST_WORDS-1.
  - After the final handshake: state register cleared, last_flag=0, k=0, go to ABSORB.
- in_last asserted together with the RATE_WORDS-th word is a normal full final block.
- in_valid outside ABSORB: no effect; the word is not consumed.
- Reset mid-operation: any in-flight permutation result is discarded via DRAIN. No partial digest is emitted.
- One permutation outstanding at most; no throughput overlap between messages.

Optional Feature:
SHA3_SEQ_STATS_EN:
- Defined: adds output perm_count [31:0].
  - Increments on every FIRE cycle and saturates at 0xFFFFFFFF.
  - Cleared by rst only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then immediate in_valid -> in_ready stays 0 for DRAIN_CYCLES (64) cycles; a perm_ogood pulse during DRAIN leaves state=0.
- Empty-message SHA3-256: one padded block, word0=0x06, word16=0x8000000000000000, in_last on word16 -> single perm_sample the cycle after word16. Digest words = a7ffc6f8bf1ed766, 51c14756a061d662, f580ff4de43b49fa, 82d80a4b80f8434a (byte-order per lane mapping); dig_last on word 3.
- Two-block message (34 words, in_last on word 33) -> exactly 2 perm_sample strobes; block 2 XORed onto the permuted state of block 1; digest matches the software model.
- Early in_last on word 4 (block padded by host, remaining words zero) -> FIRE after 5 words; lanes 5..16 unchanged; digest matches the model.
- dig_ready held low 10 cycles mid-squeeze -> dig_data/dig_valid stable; no word skipped; after the last word in_ready reasserts with the state cleared.
- rst asserted in WAIT -> outputs return to reset values immediately; the later perm_ogood is ignored; a following message hashes correctly. With SHA3_SEQ_STATS_EN, perm_count reads 0 after rst and 2 after the two-block test.
